// File: rtl/win3x3_pkg.sv
// Shared FSM state encoding and 3x3 window tap indices for win3x3_ctrl.
// Tap Pk occupies win[win_lsb(Pk, PIX_W) +: PIX_W]; P0 is the oldest row/column corner.
package win3x3_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P3 = 3;
    localparam int P4 = 4;
    localparam int P5 = 5;
    localparam int P6 = 6;
    localparam int P7 = 7;
    localparam int P8 = 8;

    function automatic int win_lsb(input int idx, input int pix_w);
        return idx * pix_w;
    endfunction

endpackage

// File: rtl/line_buf.sv
// One-row delay line: DEPTH-deep shift register advancing only when en is high.
// Latency: dout is the sample written DEPTH enables ago; no backpressure of its own.
// Backpressure: none; the caller gates en with its own handshake.
module line_buf #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // Contents are don't-care after reset, so no reset term is needed here.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/win3x3_ctrl.sv
// Raster pixel stream to 3x3 valid-mode windows; optional frame counter under WIN3X3_FRAME_CNT_EN.
// Latency: win_valid rises one cycle after the qualifying pixel is accepted.
// Backpressure: a stalled window (win_valid && !win_ready) deasserts in_ready and holds win.
module win3x3_ctrl
    import win3x3_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [PIX_W-1:0]   in_pix,
    output logic               in_ready,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [9*PIX_W-1:0] win,
    output logic               busy,
    output logic               done
`ifdef WIN3X3_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             win_valid_q, win_valid_d;
    logic [PIX_W-1:0] taps_q [9];
    logic [PIX_W-1:0] taps_d [9];
    logic [PIX_W-1:0] lb0_dout, lb1_dout;
    logic             accept, qual, last_pix;

    assign in_ready  = (state_q == ST_RUN) && (!win_valid_q || win_ready);
    assign accept    = in_valid && in_ready;
    assign qual      = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign win_valid = win_valid_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_pix) state_d = ST_DRAIN;
                end
            end
            // The final pixel always qualifies, so a window is pending here.
            ST_DRAIN: if (win_valid_q && win_ready) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        win_valid_d = win_valid_q;
        if (win_ready)       win_valid_d = 1'b0;
        if (accept && qual)  win_valid_d = 1'b1;
    end

    // Each window row shifts left; the newest column enters from the line buffers.
    always_comb begin
        taps_d = taps_q;
        if (accept) begin
            taps_d[P0] = taps_q[P1];
            taps_d[P1] = taps_q[P2];
            taps_d[P2] = lb1_dout;
            taps_d[P3] = taps_q[P4];
            taps_d[P4] = taps_q[P5];
            taps_d[P5] = lb0_dout;
            taps_d[P6] = taps_q[P7];
            taps_d[P7] = taps_q[P8];
            taps_d[P8] = in_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            for (int k = 0; k < 9; k++) taps_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            taps_q      <= taps_d;
        end
    end

    always_comb begin
        win = '0;
        for (int k = 0; k < 9; k++) begin
            win[win_lsb(k, PIX_W) +: PIX_W] = taps_q[k];
        end
    end

    line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk  (clk),
        .en   (accept),
        .din  (in_pix),
        .dout (lb0_dout)
    );

    line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk  (clk),
        .en   (accept),
        .din  (lb0_dout),
        .dout (lb1_dout)
    );

`ifdef WIN3X3_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + ((state_q == ST_DONE) ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_win3x3_ctrl.sv
// Bench for win3x3_ctrl: image-array reference model builds expected windows from pixel coordinates.
module tb_win3x3_ctrl;

    localparam int W        = 64;
    localparam int H        = 64;
    localparam int PW       = 13;
    localparam int N        = W * H;
    localparam int EXP_WINS = (W - 2) * (H - 2);
    localparam int BUDGET   = 15000;

    logic            clk = 1'b0;
    logic            rst_n, start, in_valid, in_ready, win_valid, win_ready, busy, done;
    logic [PW-1:0]   in_pix;
    logic [9*PW-1:0] win;
`ifdef WIN3X3_FRAME_CNT_EN
    logic [15:0]     frame_cnt;
`endif

    always #5 clk = ~clk;

    win3x3_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_pix    (in_pix),
        .in_ready  (in_ready),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win       (win),
        .busy      (busy),
`ifdef WIN3X3_FRAME_CNT_EN
        .done      (done),
        .frame_cnt (frame_cnt)
`else
        .done      (done)
`endif
    );

    int              checks = 0;
    int              errors = 0;
    int              frames_since_rst = 0;
    bit              timed_out = 1'b0;
    logic [PW-1:0]   img [N];
    logic [9*PW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [9*PW-1:0] obs, input logic [9*PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window for pixel index idx: rows r-2..r, columns c-2..c, row-major into p0..p8.
    function automatic logic [9*PW-1:0] build_win(input int idx);
        logic [9*PW-1:0] w;
        int r, c;
        r = idx / W;
        c = idx % W;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[k*PW +: PW] = img[(r - 2 + k / 3) * W + (c - 2 + k % 3)];
        end
        return w;
    endfunction

    task automatic do_abort();
        rst_n = 1'b0;
        #1;
        chk("abort_win_valid", win_valid, 0);
        chk("abort_in_ready",  in_ready,  0);
        chk("abort_busy",      busy,      0);
        chk("abort_done",      done,      0);
        chk("abort_win",       win,       0);
        exp_q.delete();
        frames_since_rst = 0;
        in_valid  = 1'b1;
        in_pix    = PW'($urandom);
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_abort_win_valid", win_valid, 0);
            chk("post_abort_in_ready",  in_ready,  0);
            @(posedge clk);
            #1 in_pix = PW'($urandom);
        end
        in_valid = 1'b0;
`ifdef WIN3X3_FRAME_CNT_EN
        chk("abort_frame_cnt", frame_cnt, 0);
`endif
    endtask

    // pat: 0 = row*64+col, 1 = random; vmode: 0 always, 1 every other cycle, 2 random;
    // rmode: 0 always ready, 1 five-cycle stall at window 10, 2 random.
    task automatic run_frame(input int pat, input int vmode, input int rmode,
                             input int abort_at, input bit start_mid);
        int pix_idx, win_cnt, stall_left, last_hs;
        bit done_seen, prev_stall, qual_prev, acc, hs;
        logic [9*PW-1:0] prev_win, w;
        if (timed_out) return;
        pix_idx = 0; win_cnt = 0; stall_left = 0; last_hs = -10;
        done_seen = 0; prev_stall = 0; qual_prev = 0; prev_win = '0;
        for (int i = 0; i < N; i++) begin
            img[i] = (pat == 0) ? PW'((i / W) * 64 + (i % W)) : PW'($urandom);
        end
        exp_q.delete();
        start = 1'b1; in_valid = 1'b0; win_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !done_seen; cyc++) begin
            case (vmode)
                0:       in_valid = (pix_idx < N);
                1:       in_valid = (cyc % 2 == 0) && (pix_idx < N);
                default: in_valid = ($urandom_range(3) != 0) && (pix_idx < N);
            endcase
            in_pix = in_valid ? img[pix_idx] : PW'($urandom);
            case (rmode)
                0:       win_ready = 1'b1;
                1:       win_ready = (stall_left == 0);
                default: win_ready = 1'($urandom_range(1));
            endcase
            start = start_mid && (cyc == 300 || cyc == 3000);
            @(negedge clk);
            acc = in_valid && in_ready;
            hs  = win_valid && win_ready;
            if (cyc == 0) chk("busy_after_start", busy, 1);
            if (qual_prev) chk("win_latency", win_valid, 1);
            if (prev_stall) chk("stall_hold", win, prev_win);
            if (win_valid && !win_ready) chk("stall_in_ready", in_ready, 0);
            prev_stall = win_valid && !win_ready;
            prev_win   = win;
            if (rmode == 1 && !win_ready && stall_left > 0) stall_left--;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("win_expected", exp_q.size() != 0, 1);
                end else begin
                    w = exp_q.pop_front();
                    chk("win_data", win, w);
                end
                if (win_cnt == 0 && pat == 0) begin
                    chk("first_p0", win[0 +: PW], 0);
                    chk("first_p8", win[8*PW +: PW], 130);
                end
                win_cnt++;
                last_hs = cyc;
                if (rmode == 1 && win_cnt == 9) stall_left = 5;
            end
            if (done) begin
                done_seen = 1;
                chk("done_after_last_hs", cyc, last_hs + 1);
                chk("win_count", win_cnt, EXP_WINS);
                chk("queue_empty", exp_q.size(), 0);
                chk("pix_count", pix_idx, N);
                frames_since_rst++;
            end
            qual_prev = 0;
            if (acc) begin
                if (pix_idx / W >= 2 && pix_idx % W >= 2) begin
                    exp_q.push_back(build_win(pix_idx));
                    qual_prev = 1;
                end
                pix_idx++;
            end
            if (abort_at > 0 && pix_idx == abort_at) begin
                start = 1'b0;
                do_abort();
                return;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (!done_seen) begin
            chk("frame_timeout", done_seen, 1);
            timed_out = 1'b1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pix = '0; win_ready = 1'b0;
        #1;
        chk("rst_win_valid", win_valid, 0);
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_busy",      busy,      0);
        chk("rst_done",      done,      0);
        chk("rst_win",       win,       0);
`ifdef WIN3X3_FRAME_CNT_EN
        chk("rst_frame_cnt", frame_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(0, 0, 0, 0,    1'b0);
        run_frame(0, 0, 1, 0,    1'b0);
        run_frame(0, 1, 0, 0,    1'b0);
        run_frame(0, 0, 0, 2000, 1'b0);
        run_frame(0, 0, 0, 0,    1'b0);
        run_frame(1, 2, 2, 0,    1'b1);
        run_frame(1, 2, 0, 0,    1'b0);
`ifdef WIN3X3_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, frames_since_rst);
        chk("frame_cnt_three", frame_cnt, 3);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
